snk_input_conditioner: RTL and testbench
========================================

SNK_INPUT_CONDITIONER -- requirements
Module: snk_input_conditioner

Interface
REQ-001 The block SHALL take these parameters (name, default, meaning): DEB_TICKS, 4, cen ticks a raw bit must hold steady before its output follows it.
REQ-002 COIN_PULSE, 8, cen ticks a coin output stays asserted per accepted coin.
REQ-003 COIN_GAP, 8, cen ticks after a coin pulse during which new coins are refused.
REQ-004 The ports SHALL be (name, direction, width, meaning): i_clk, in, 1, 53.6 MHz system clock.
REQ-005 RESETn, in, 1, reset; one clock; reset is asynchronous and active-low.
REQ-006 cen, in, 1, tick enable, driven from player_ctrl_clk (3.35 MHz cen).
REQ-007 pause, in, 1, freezes all state when high.
REQ-008 joy1_raw, in, 16, player-1 raw inputs, active-high, asynchronous to i_clk.
REQ-009 joy2_raw, in, 16, player-2 raw inputs, active-high, asynchronous to i_clk.
REQ-010 PLAYER1, out, 16, conditioned player-1 inputs, active-low.
REQ-011 PLAYER2, out, 16, conditioned player-2 inputs, active-low.
REQ-012 coin_busy, out, 2, per-player coin FSM not IDLE (bit 0 = P1).

Function
REQ-013 Every raw bit SHALL pass through a 2-flop synchronizer on i_clk; the synchronizer is clocked every i_clk cycle, independent of cen and pause.
REQ-014 Each non-coin bit SHALL have its own debounce counter, advanced only on cycles with cen=1 and pause=0.
REQ-015 The counter SHALL clear whenever the synchronized bit equals the debounced state.
REQ-016 When the synchronized bit differs for DEB_TICKS consecutive ticks, the debounced state SHALL take the new value and the counter SHALL clear.
REQ-017 A toggle shorter than DEB_TICKS ticks SHALL never reach the output.
REQ-018 Each output bit SHALL be the inverse of its debounced or FSM state, registered, so an output changes one i_clk cycle after the deciding tick.
REQ-019 Coin bit COIN_IDX SHALL be debounced as in REQ-014..017 and then drive a per-player FSM with states IDLE, PULSE, GAP, WAIT_REL.
REQ-020 FSM transition IDLE->PULSE SHALL occur on the tick where the debounced coin rises; coin output is asserted (low) throughout PULSE.
REQ-021 FSM transition PULSE->GAP SHALL occur after exactly COIN_PULSE ticks; coin output is deasserted in GAP.
REQ-022 FSM transition GAP->WAIT_REL SHALL occur after COIN_GAP ticks if the debounced coin is still high; otherwise the FSM SHALL go to IDLE.
REQ-023 FSM transition WAIT_REL->IDLE SHALL occur when the debounced coin is low; a held coin SHALL yield exactly one pulse.
REQ-024 A coin press arriving during PULSE or GAP SHALL be ignored; no queuing is allowed.
REQ-025 Both player FSMs SHALL run independently; simultaneous coins SHALL produce simultaneous pulses.
REQ-026 With pause=1, all outputs, counters and FSMs SHALL hold; on release they resume from the held values.
REQ-027 Counters SHALL saturate at their terminal value and never wrap; counter widths SHALL be clog2(max parameter + 1).

Reset
REQ-028 On RESETn low, PLAYER1 and PLAYER2 SHALL be 16'hFFFF, coin_busy 2'b00, synchronizers 0, debounced states 0, counters 0, and both FSMs IDLE.
REQ-029 Reset asserted mid-PULSE SHALL deassert the coin output immediately; after release, a still-held coin SHALL be accepted as a new press only after debounce.

Structure
REQ-030 Package snk_input_pkg SHALL hold COIN_IDX (9), START_IDX (8), the bit-map constants and the coin_state_t enum.
REQ-031 Sub-module snk_debounce SHALL hold one synchronizer and one debounce counter per bit, instantiated 32 times.
REQ-032 The coin FSM SHALL be written inline and generated per player.

Verification
REQ-033 Reset, then joy1_raw[0]=1 held for 4 ticks -> PLAYER1[0]=0 one cycle after the 4th tick; PLAYER1[0] is still 1 after 3 ticks.
REQ-034 A 2-tick glitch on joy2_raw[5] -> PLAYER2 stays 16'hFFFF.
REQ-035 joy1_raw[9] held for 100 ticks -> PLAYER1[9] low for exactly 8 ticks, one pulse only, and coin_busy[0] drops after release plus debounce.
REQ-036 Second coin press during GAP -> no second pulse; a press after IDLE -> a second 8-tick pulse.
REQ-037 pause=1 asserted mid-PULSE for 50 ticks -> PLAYER1[9] stays low, and the pulse completes its remaining ticks after pause drops.
REQ-038 RESETn pulsed low mid-PULSE -> PLAYER1 reads 16'hFFFF asynchronously, before the next i_clk edge.

Source files
------------

// File: rtl/snk_input_pkg.sv
// Shared constants for the SNK player input conditioner: joystick bit map
// and the coin acceptor state encoding.
package snk_input_pkg;

    localparam int NUM_BITS  = 16;

    localparam int UP_IDX    = 0;
    localparam int DOWN_IDX  = 1;
    localparam int LEFT_IDX  = 2;
    localparam int RIGHT_IDX = 3;
    localparam int BTN_A_IDX = 4;
    localparam int BTN_B_IDX = 5;
    localparam int BTN_C_IDX = 6;
    localparam int BTN_D_IDX = 7;
    localparam int START_IDX = 8;
    localparam int COIN_IDX  = 9;

    typedef enum logic [1:0] {
        IDLE,
        PULSE,
        GAP,
        WAIT_REL
    } coin_state_t;

endpackage

// File: rtl/snk_debounce.sv
// One input bit: 2-flop synchronizer into i_clk, then a tick-driven debounce
// counter that lets the bit through only after it holds for DEB_TICKS ticks.
module snk_debounce #(
    parameter int DEB_TICKS = 4
) (
    input  logic i_clk,
    input  logic RESETn,
    input  logic tick,
    input  logic raw,
    output logic deb
);

    localparam int CW = $clog2(DEB_TICKS + 1);

    logic [1:0]    sync;
    logic [CW-1:0] cnt;

    // The synchronizer runs every clock; only the debounce state honours tick.
    always_ff @(posedge i_clk or negedge RESETn) begin
        if (!RESETn) begin
            sync <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            sync <= {sync[0], raw};
        end
    end

    always_ff @(posedge i_clk or negedge RESETn) begin
        if (!RESETn) begin
            deb <= 1'b0;
            cnt <= '0;
        end else if (tick) begin
            if (sync[1] == deb) begin
                cnt <= '0;
            end else if (cnt == CW'(DEB_TICKS - 1)) begin
                deb <= sync[1];
                cnt <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/snk_input_conditioner.sv
// Debounces both players' raw inputs and turns each coin switch into a single
// fixed-length, active-low coin pulse with a refusal gap afterwards.
module snk_input_conditioner
    import snk_input_pkg::*;
#(
    parameter int DEB_TICKS  = 4,
    parameter int COIN_PULSE = 8,
    parameter int COIN_GAP   = 8
) (
    input  logic                i_clk,
    input  logic                RESETn,
    input  logic                cen,
    input  logic                pause,
    input  logic [NUM_BITS-1:0] joy1_raw,
    input  logic [NUM_BITS-1:0] joy2_raw,
    output logic [NUM_BITS-1:0] PLAYER1,
    output logic [NUM_BITS-1:0] PLAYER2,
    output logic [1:0]          coin_busy
);

    localparam int COIN_MAX = (COIN_PULSE > COIN_GAP) ? COIN_PULSE : COIN_GAP;
    localparam int COIN_CW  = $clog2(COIN_MAX + 1);

    logic                  tick;
    logic [2*NUM_BITS-1:0] raw_all;
    logic [2*NUM_BITS-1:0] deb_all;
    logic [2*NUM_BITS-1:0] cond;
    logic [1:0]            pulse_on;

    assign tick    = cen & ~pause;
    assign raw_all = {joy2_raw, joy1_raw};

    for (genvar i = 0; i < 2 * NUM_BITS; i++) begin : g_bit
        snk_debounce #(.DEB_TICKS(DEB_TICKS)) u_deb (
            .i_clk  (i_clk),
            .RESETn (RESETn),
            .tick   (tick),
            .raw    (raw_all[i]),
            .deb    (deb_all[i])
        );
    end

    // IDLE reacts to the debounced coin being high; reaching IDLE always
    // requires it low, so this only fires on a fresh press.
    for (genvar p = 0; p < 2; p++) begin : g_coin
        coin_state_t        state, state_next;
        logic [COIN_CW-1:0] cnt, cnt_next;
        logic               coin;

        assign coin = deb_all[p*NUM_BITS + COIN_IDX];

        always_ff @(posedge i_clk or negedge RESETn) begin
            if (!RESETn) begin
                state <= IDLE;
                cnt   <= '0;
            end else begin
                state <= state_next;
                cnt   <= cnt_next;
            end
        end

        always_comb begin
            // NOTE: defaults first so no path leaves a signal unassigned (no latch).
            state_next = state;
            cnt_next   = cnt;
            if (tick) begin
                case (state)
                    IDLE: begin
                        if (coin) begin
                            state_next = PULSE;
                            cnt_next   = '0;
                        end
                    end
                    PULSE: begin
                        if (cnt == COIN_CW'(COIN_PULSE - 1)) begin
                            state_next = GAP;
                            cnt_next   = '0;
                        end else begin
                            cnt_next = cnt + COIN_CW'(1);
                        end
                    end
                    GAP: begin
                        if (cnt == COIN_CW'(COIN_GAP - 1)) begin
                            state_next = coin ? WAIT_REL : IDLE;
                            cnt_next   = '0;
                        end else begin
                            cnt_next = cnt + COIN_CW'(1);
                        end
                    end
                    WAIT_REL: begin
                        if (!coin) state_next = IDLE;
                    end
                    default: state_next = IDLE;
                endcase
            end
        end

        assign pulse_on[p]  = (state == PULSE);
        assign coin_busy[p] = (state != IDLE);
    end

    always_comb begin
        cond                      = ~deb_all;
        cond[COIN_IDX]            = ~pulse_on[0];
        cond[NUM_BITS + COIN_IDX] = ~pulse_on[1];
    end

    always_ff @(posedge i_clk or negedge RESETn) begin
        if (!RESETn) begin
            {PLAYER2, PLAYER1} <= '1;
        end else begin
            {PLAYER2, PLAYER1} <= cond;
        end
    end

endmodule

// File: tb/tb_snk_input_conditioner.sv
// Directed bench for snk_input_conditioner: debounce, glitch rejection, coin
// pulse shaping, gap refusal, pause hold and asynchronous reset.
module tb_snk_input_conditioner;

    logic        i_clk;
    logic        RESETn;
    logic        cen;
    logic        pause;
    logic [15:0] joy1_raw;
    logic [15:0] joy2_raw;
    logic [15:0] PLAYER1;
    logic [15:0] PLAYER2;
    logic [1:0]  coin_busy;

    int   checks;
    int   fails;
    int   lows;
    int   falls;
    logic prev;

    snk_input_conditioner #(
        .DEB_TICKS  (4),
        .COIN_PULSE (8),
        .COIN_GAP   (8)
    ) dut (
        .i_clk     (i_clk),
        .RESETn    (RESETn),
        .cen       (cen),
        .pause     (pause),
        .joy1_raw  (joy1_raw),
        .joy2_raw  (joy2_raw),
        .PLAYER1   (PLAYER1),
        .PLAYER2   (PLAYER2),
        .coin_busy (coin_busy)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // One cen tick, returning once the output register has caught up.
    task automatic tick();
        @(negedge i_clk) cen = 1'b1;
        @(negedge i_clk) cen = 1'b0;
        @(negedge i_clk);
    endtask

    task automatic settle();
        repeat (3) @(negedge i_clk);
    endtask

    task automatic coin_tick();
        tick();
        if (PLAYER1[9] === 1'b0) begin
            lows++;
            if (prev === 1'b1) falls++;
        end
        prev = PLAYER1[9];
    endtask

    task automatic do_reset();
        joy1_raw = '0;
        joy2_raw = '0;
        pause    = 1'b0;
        cen      = 1'b0;
        RESETn   = 1'b0;
        repeat (3) @(negedge i_clk);
        RESETn = 1'b1;
        @(negedge i_clk);
        lows  = 0;
        falls = 0;
        prev  = 1'b1;
    endtask

    task automatic test_reset();
        RESETn   = 1'b0;
        pause    = 1'b0;
        cen      = 1'b1;
        joy1_raw = 16'hFFFF;
        joy2_raw = 16'hFFFF;
        repeat (4) @(negedge i_clk);
        checks++;
        if (PLAYER1 !== 16'hFFFF) begin
            fails++;
            $display("FAIL reset_p1: got %h expected ffff", PLAYER1);
        end
        checks++;
        if (PLAYER2 !== 16'hFFFF) begin
            fails++;
            $display("FAIL reset_p2: got %h expected ffff", PLAYER2);
        end
        checks++;
        if (coin_busy !== 2'b00) begin
            fails++;
            $display("FAIL reset_busy: got %b expected 00", coin_busy);
        end
        do_reset();
    endtask

    task automatic test_debounce();
        do_reset();
        joy1_raw[0] = 1'b1;
        settle();
        repeat (3) tick();
        checks++;
        if (PLAYER1 !== 16'hFFFF) begin
            fails++;
            $display("FAIL deb_3ticks: got %h expected ffff", PLAYER1);
        end
        @(negedge i_clk) cen = 1'b1;
        @(negedge i_clk) cen = 1'b0;
        checks++;
        if (PLAYER1 !== 16'hFFFF) begin
            fails++;
            $display("FAIL deb_same_cycle: got %h expected ffff", PLAYER1);
        end
        @(negedge i_clk);
        checks++;
        if (PLAYER1 !== 16'hFFFE) begin
            fails++;
            $display("FAIL deb_4ticks: got %h expected fffe", PLAYER1);
        end
        joy1_raw[0] = 1'b0;
        settle();
        repeat (3) tick();
        checks++;
        if (PLAYER1 !== 16'hFFFE) begin
            fails++;
            $display("FAIL deb_release_3: got %h expected fffe", PLAYER1);
        end
        tick();
        checks++;
        if (PLAYER1 !== 16'hFFFF) begin
            fails++;
            $display("FAIL deb_release_4: got %h expected ffff", PLAYER1);
        end
    endtask

    task automatic test_glitch();
        do_reset();
        joy2_raw[5] = 1'b1;
        settle();
        repeat (2) tick();
        joy2_raw[5] = 1'b0;
        settle();
        for (int t = 0; t < 6; t++) begin
            tick();
            checks++;
            if (PLAYER2 !== 16'hFFFF) begin
                fails++;
                $display("FAIL glitch2_p2 tick %0d: got %h expected ffff", t, PLAYER2);
            end
        end
        joy1_raw[3] = 1'b1;
        settle();
        repeat (3) tick();
        joy1_raw[3] = 1'b0;
        settle();
        repeat (4) tick();
        checks++;
        if (PLAYER1 !== 16'hFFFF) begin
            fails++;
            $display("FAIL glitch3_p1: got %h expected ffff", PLAYER1);
        end
    endtask

    task automatic test_coin_hold();
        int first_low;
        do_reset();
        first_low = 0;
        joy1_raw[9] = 1'b1;
        settle();
        for (int t = 1; t <= 100; t++) begin
            coin_tick();
            if (first_low == 0 && PLAYER1[9] === 1'b0) first_low = t;
            if (t == 5) begin
                checks++;
                if (PLAYER1 !== 16'hFDFF) begin
                    fails++;
                    $display("FAIL coin_pulse_value: got %h expected fdff", PLAYER1);
                end
            end
        end
        checks++;
        if (first_low != 5) begin
            fails++;
            $display("FAIL coin_first_low: got %0d expected 5", first_low);
        end
        checks++;
        if (lows != 8) begin
            fails++;
            $display("FAIL coin_low_ticks: got %0d expected 8", lows);
        end
        checks++;
        if (falls != 1) begin
            fails++;
            $display("FAIL coin_pulse_count: got %0d expected 1", falls);
        end
        checks++;
        if (coin_busy !== 2'b01) begin
            fails++;
            $display("FAIL coin_busy_held: got %b expected 01", coin_busy);
        end
        joy1_raw[9] = 1'b0;
        settle();
        repeat (4) tick();
        checks++;
        if (coin_busy !== 2'b01) begin
            fails++;
            $display("FAIL coin_busy_rel4: got %b expected 01", coin_busy);
        end
        tick();
        checks++;
        if (coin_busy !== 2'b00) begin
            fails++;
            $display("FAIL coin_busy_rel5: got %b expected 00", coin_busy);
        end
    endtask

    task automatic test_gap_press();
        do_reset();
        joy1_raw[9] = 1'b1;
        settle();
        repeat (8) coin_tick();
        joy1_raw[9] = 1'b0;
        settle();
        repeat (5) coin_tick();
        joy1_raw[9] = 1'b1;
        settle();
        repeat (12) coin_tick();
        checks++;
        if (lows != 8 || falls != 1) begin
            fails++;
            $display("FAIL gap_press: got lows=%0d pulses=%0d expected lows=8 pulses=1", lows, falls);
        end
        checks++;
        if (coin_busy !== 2'b01) begin
            fails++;
            $display("FAIL gap_wait_rel: got %b expected 01", coin_busy);
        end
        joy1_raw[9] = 1'b0;
        settle();
        repeat (5) coin_tick();
        checks++;
        if (coin_busy !== 2'b00) begin
            fails++;
            $display("FAIL gap_idle: got %b expected 00", coin_busy);
        end
        joy1_raw[9] = 1'b1;
        settle();
        repeat (20) coin_tick();
        checks++;
        if (lows != 16 || falls != 2) begin
            fails++;
            $display("FAIL second_coin: got lows=%0d pulses=%0d expected lows=16 pulses=2", lows, falls);
        end
    endtask

    task automatic test_pause();
        do_reset();
        joy1_raw[9] = 1'b1;
        settle();
        repeat (8) coin_tick();
        checks++;
        if (lows != 4) begin
            fails++;
            $display("FAIL pause_pre_lows: got %0d expected 4", lows);
        end
        pause = 1'b1;
        for (int t = 0; t < 50; t++) begin
            tick();
            checks++;
            if (PLAYER1[9] !== 1'b0) begin
                fails++;
                $display("FAIL pause_hold tick %0d: got %b expected 0", t, PLAYER1[9]);
            end
        end
        pause = 1'b0;
        repeat (4) coin_tick();
        checks++;
        if (lows != 8 || PLAYER1[9] !== 1'b0) begin
            fails++;
            $display("FAIL pause_resume: got lows=%0d bit=%b expected lows=8 bit=0", lows, PLAYER1[9]);
        end
        coin_tick();
        checks++;
        if (PLAYER1[9] !== 1'b1 || coin_busy !== 2'b01) begin
            fails++;
            $display("FAIL pause_end: got bit=%b busy=%b expected bit=1 busy=01", PLAYER1[9], coin_busy);
        end
    endtask

    task automatic test_reset_mid_pulse();
        do_reset();
        joy1_raw[9] = 1'b1;
        settle();
        repeat (6) tick();
        checks++;
        if (PLAYER1 !== 16'hFDFF) begin
            fails++;
            $display("FAIL rst_pre: got %h expected fdff", PLAYER1);
        end
        @(negedge i_clk);
        #1 RESETn = 1'b0;
        #1;
        checks++;
        if (PLAYER1 !== 16'hFFFF || coin_busy !== 2'b00) begin
            fails++;
            $display("FAIL rst_async: got p1=%h busy=%b expected p1=ffff busy=00", PLAYER1, coin_busy);
        end
        @(negedge i_clk) RESETn = 1'b1;
        settle();
        repeat (4) tick();
        checks++;
        if (PLAYER1 !== 16'hFFFF) begin
            fails++;
            $display("FAIL rst_redebounce: got %h expected ffff", PLAYER1);
        end
        tick();
        checks++;
        if (PLAYER1 !== 16'hFDFF) begin
            fails++;
            $display("FAIL rst_new_press: got %h expected fdff", PLAYER1);
        end
    endtask

    task automatic test_both_players();
        do_reset();
        joy1_raw[9] = 1'b1;
        joy2_raw[9] = 1'b1;
        joy2_raw[8] = 1'b1;
        settle();
        repeat (4) tick();
        checks++;
        if (PLAYER2 !== 16'hFEFF || coin_busy !== 2'b00) begin
            fails++;
            $display("FAIL both_deb: got p2=%h busy=%b expected p2=feff busy=00", PLAYER2, coin_busy);
        end
        tick();
        checks++;
        if (PLAYER1 !== 16'hFDFF || PLAYER2 !== 16'hFCFF || coin_busy !== 2'b11) begin
            fails++;
            $display("FAIL both_pulse: got p1=%h p2=%h busy=%b expected p1=fdff p2=fcff busy=11",
                     PLAYER1, PLAYER2, coin_busy);
        end
    endtask

    initial begin
        checks   = 0;
        fails    = 0;
        lows     = 0;
        falls    = 0;
        prev     = 1'b1;
        RESETn   = 1'b0;
        cen      = 1'b0;
        pause    = 1'b0;
        joy1_raw = '0;
        joy2_raw = '0;
        test_reset();
        test_debounce();
        test_glitch();
        test_coin_hold();
        test_gap_press();
        test_pause();
        test_reset_mid_pulse();
        test_both_players();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
